// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage PC generator.
// Next-PC source select, increment sizes and alignment.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_RAS,
    SEL_BR,
    SEL_TRAP
  } next_sel_e;

  localparam int INC4 = 4;
  localparam int INC2 = 2;

  function automatic logic [63:0] align_pc(
    input logic [63:0] addr,
    input logic        c_en
  );
    logic [63:0] r;
    r = addr;
    r[0] = 1'b0;
    if (!c_en) r[1] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: redirects,
// RAS hints and the registered PC back to fetch.
interface pc_gen_if #(
  parameter int W         = 32,
  parameter int RAS_DEPTH = 4
);
  logic                         stall_i;
  logic                         inc2_i;
  logic                         trap_valid_i;
  logic [W-1:0]                 trap_pc_i;
  logic                         br_valid_i;
  logic [W-1:0]                 br_target_i;
  logic                         ras_push_i;
  logic                         ras_pop_i;
  logic [W-1:0]                 pc_o;
  logic                         pc_valid_o;
  logic [$clog2(RAS_DEPTH):0]   ras_count_o;
  logic                         ras_underflow_o;

  modport slave (
    input  stall_i, inc2_i,
    input  trap_valid_i, trap_pc_i,
    input  br_valid_i, br_target_i,
    input  ras_push_i, ras_pop_i,
    output pc_o, pc_valid_o,
    output ras_count_o, ras_underflow_o
  );

  modport master (
    output stall_i, inc2_i,
    output trap_valid_i, trap_pc_i,
    output br_valid_i, br_target_i,
    output ras_push_i, ras_pop_i,
    input  pc_o, pc_valid_o,
    input  ras_count_o, ras_underflow_o
  );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack with saturating count;
// a full push silently overwrites the oldest entry.
module ras_stack #(
  parameter  int W         = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_top,
  output logic [CW-1:0] o_count,
  output logic          o_underflow
);

  logic [W-1:0]  r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic          r_uf;

  logic [PW-1:0] w_tos;
  logic          w_empty;
  logic          w_full;
  logic          w_swap;
  logic          w_push;
  logic          w_pop;

  assign w_tos   = r_ptr - PW'(1);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(RAS_DEPTH));
  assign w_swap  = i_push && i_pop && !w_empty;
  assign w_push  = i_push && !w_swap;
  assign w_pop   = i_pop && !i_push && !w_empty;

  always_ff @(posedge clk_i) begin
    if (!i_clear) begin
      if (w_swap)      r_mem[w_tos] <= i_wdata;
      else if (w_push) r_mem[r_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_uf    <= 1'b0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_uf <= i_pop && w_empty;
      if (w_push) begin
        r_ptr <= r_ptr + PW'(1);
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_ptr   <= w_tos;
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_top       = r_mem[w_tos];
  assign o_count     = r_count;
  assign o_underflow = r_uf;

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: trap > branch > RAS pop > sequential,
// with stall hold and a registered PC/valid pair.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter bit           C_EN      = 1'b0,
  parameter int           RAS_DEPTH = 4
) (
  input logic     clk_i,
  input logic     rst_ni,
  pc_gen_if.slave bus
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [W-1:0]  r_pc;
  logic          r_valid;

  logic [W-1:0]  w_inc;
  logic [W-1:0]  w_seq;
  logic [W-1:0]  w_raw;
  logic [W-1:0]  w_next;
  logic [W-1:0]  w_top;
  logic [CW-1:0] w_count;
  logic          w_uf;
  logic          w_go;
  logic          w_rpop;
  next_sel_e     w_sel;

  assign w_inc = (C_EN && bus.inc2_i) ? W'(INC2) : W'(INC4);
  assign w_seq = r_pc + w_inc;

  // RAS only moves on an unstalled, non-flushed cycle
  assign w_go   = !bus.stall_i && !bus.trap_valid_i
                  && !bus.br_valid_i;
  assign w_rpop = bus.ras_pop_i && (w_count != '0);

  always_comb begin
    w_sel = SEL_HOLD;
    unique case (1'b1)
      bus.trap_valid_i:
        w_sel = SEL_TRAP;
      (!bus.trap_valid_i && bus.br_valid_i):
        w_sel = SEL_BR;
      (w_go && w_rpop):
        w_sel = SEL_RAS;
      (w_go && !w_rpop):
        w_sel = SEL_SEQ;
      default:
        w_sel = SEL_HOLD;
    endcase
  end

  always_comb begin
    w_raw = r_pc;
    unique case (w_sel)
      SEL_TRAP: w_raw = bus.trap_pc_i;
      SEL_BR:   w_raw = bus.br_target_i;
      SEL_RAS:  w_raw = w_top;
      SEL_SEQ:  w_raw = w_seq;
      default:  w_raw = r_pc;
    endcase
  end

  assign w_next = W'(align_pc(64'(w_raw), C_EN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_sel != SEL_HOLD);
      if (w_sel != SEL_HOLD) r_pc <= w_next;
    end
  end

  ras_stack #(
    .W         (W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_go && bus.ras_push_i),
    .i_pop       (w_go && bus.ras_pop_i),
    .i_clear     (bus.trap_valid_i),
    .i_wdata     (w_seq),
    .o_top       (w_top),
    .o_count     (w_count),
    .o_underflow (w_uf)
  );

  assign bus.pc_o            = r_pc;
  assign bus.pc_valid_o      = r_valid;
  assign bus.ras_count_o     = w_count;
  assign bus.ras_underflow_o = w_uf;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one 4-byte and one
// compressed-enabled instance sharing clock and reset.
module tb_pc_gen;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pc_gen_if #(.W(32), .RAS_DEPTH(4)) if0 ();
  pc_gen_if #(.W(32), .RAS_DEPTH(4)) if1 ();

  pc_gen #(
    .W(32), .RESET_VEC(32'h0), .C_EN(1'b0), .RAS_DEPTH(4)
  ) u_dut0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if0.slave)
  );

  pc_gen #(
    .W(32), .RESET_VEC(32'h0), .C_EN(1'b1), .RAS_DEPTH(4)
  ) u_dut1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if1.slave)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic br0(input logic [31:0] a);
    if0.br_valid_i  = 1'b1;
    if0.br_target_i = a;
    tick();
    if0.br_valid_i  = 1'b0;
  endtask

  task automatic push0();
    if0.ras_push_i = 1'b1;
    tick();
    if0.ras_push_i = 1'b0;
  endtask

  task automatic pop0();
    if0.ras_pop_i = 1'b1;
    tick();
    if0.ras_pop_i = 1'b0;
  endtask

  logic [31:0] exp_ret [4];

  initial begin
    exp_ret[0] = 32'h144;
    exp_ret[1] = 32'h104;
    exp_ret[2] = 32'hC4;
    exp_ret[3] = 32'h84;

    if0.stall_i = 1'b0;  if1.stall_i = 1'b1;
    if0.inc2_i  = 1'b0;  if1.inc2_i  = 1'b0;
    if0.trap_valid_i = 1'b0; if1.trap_valid_i = 1'b0;
    if0.trap_pc_i    = '0;   if1.trap_pc_i    = '0;
    if0.br_valid_i   = 1'b0; if1.br_valid_i   = 1'b0;
    if0.br_target_i  = '0;   if1.br_target_i  = '0;
    if0.ras_push_i   = 1'b0; if1.ras_push_i   = 1'b0;
    if0.ras_pop_i    = 1'b0; if1.ras_pop_i    = 1'b0;

    // reset state
    #12;
    check("rst_pc", 64'(if0.pc_o), 64'h0);
    check("rst_valid", 64'(if0.pc_valid_o), 64'h0);
    check("rst_cnt", 64'(if0.ras_count_o), 64'h0);
    check("rst_uf", 64'(if0.ras_underflow_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // sequential advance
    check("seq_pc0", 64'(if0.pc_o), 64'h0);
    tick();
    check("seq_pc4", 64'(if0.pc_o), 64'h4);
    check("seq_v4", 64'(if0.pc_valid_o), 64'h1);
    tick();
    check("seq_pc8", 64'(if0.pc_o), 64'h8);
    tick();
    check("seq_pcC", 64'(if0.pc_o), 64'hC);

    // trap+branch under stall, trap clears RAS
    push0();
    check("pre_trap_cnt", 64'(if0.ras_count_o), 64'h1);
    if0.stall_i      = 1'b1;
    if0.trap_valid_i = 1'b1;
    if0.trap_pc_i    = 32'h100;
    if0.br_valid_i   = 1'b1;
    if0.br_target_i  = 32'h200;
    tick();
    if0.trap_valid_i = 1'b0;
    if0.br_valid_i   = 1'b0;
    check("trap_pc", 64'(if0.pc_o), 64'h100);
    check("trap_valid", 64'(if0.pc_valid_o), 64'h1);
    check("trap_cnt", 64'(if0.ras_count_o), 64'h0);
    tick();
    check("stall_pc", 64'(if0.pc_o), 64'h100);
    check("stall_valid", 64'(if0.pc_valid_o), 64'h0);

    // compressed increment and alignment
    if1.br_valid_i  = 1'b1;
    if1.br_target_i = 32'h10;
    tick();
    check("c_br", 64'(if1.pc_o), 64'h10);
    if1.br_valid_i = 1'b0;
    if1.stall_i    = 1'b0;
    if1.inc2_i     = 1'b1;
    tick();
    check("c_inc2", 64'(if1.pc_o), 64'h12);
    if1.inc2_i = 1'b0;
    tick();
    check("c_inc4", 64'(if1.pc_o), 64'h16);
    if1.br_valid_i  = 1'b1;
    if1.br_target_i = 32'h31;
    tick();
    check("c_align", 64'(if1.pc_o), 64'h30);
    if1.br_target_i = 32'h33;
    tick();
    check("c_align2", 64'(if1.pc_o), 64'h32);
    if1.br_valid_i = 1'b0;
    if1.stall_i    = 1'b1;

    // RAS fill beyond depth, then drain
    if0.stall_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      br0(32'(i * 32'h40));
      push0();
      check("push_pc", 64'(if0.pc_o), 64'(i * 32'h40 + 4));
    end
    check("ras_sat", 64'(if0.ras_count_o), 64'h4);
    for (int i = 0; i < 4; i++) begin
      pop0();
      check("pop_pc", 64'(if0.pc_o), 64'(exp_ret[i]));
      check("pop_cnt", 64'(if0.ras_count_o), 64'(3 - i));
    end
    pop0();
    check("uf_pc", 64'(if0.pc_o), 64'h88);
    check("uf_pulse", 64'(if0.ras_underflow_o), 64'h1);
    check("uf_cnt", 64'(if0.ras_count_o), 64'h0);
    tick();
    check("uf_clear", 64'(if0.ras_underflow_o), 64'h0);
    check("uf_seq", 64'(if0.pc_o), 64'h8C);

    // co-routine push+pop
    br0(32'h4FC);
    push0();
    check("co_pre", 64'(if0.pc_o), 64'h500);
    br0(32'h20);
    if0.ras_push_i = 1'b1;
    if0.ras_pop_i  = 1'b1;
    tick();
    if0.ras_push_i = 1'b0;
    if0.ras_pop_i  = 1'b0;
    check("co_pc", 64'(if0.pc_o), 64'h500);
    check("co_cnt", 64'(if0.ras_count_o), 64'h1);
    pop0();
    check("co_top", 64'(if0.pc_o), 64'h24);
    check("co_cnt0", 64'(if0.ras_count_o), 64'h0);

    // stall ignores RAS ops, then async reset
    br0(32'h7C);
    push0();
    push0();
    push0();
    check("pre_pc", 64'(if0.pc_o), 64'h88);
    check("pre_cnt", 64'(if0.ras_count_o), 64'h3);
    if0.stall_i    = 1'b1;
    if0.ras_push_i = 1'b1;
    if0.ras_pop_i  = 1'b1;
    tick();
    check("hold_pc", 64'(if0.pc_o), 64'h88);
    check("hold_cnt", 64'(if0.ras_count_o), 64'h3);
    check("hold_v", 64'(if0.pc_valid_o), 64'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_pc", 64'(if0.pc_o), 64'h0);
    check("arst_cnt", 64'(if0.ras_count_o), 64'h0);
    check("arst_v", 64'(if0.pc_valid_o), 64'h0);
    if0.stall_i    = 1'b0;
    if0.ras_push_i = 1'b0;
    if0.ras_pop_i  = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // wrap and 4-byte alignment
    br0(32'hFFFF_FFFC);
    check("wrap_pre", 64'(if0.pc_o), 64'hFFFF_FFFC);
    tick();
    check("wrap_pc", 64'(if0.pc_o), 64'h0);
    br0(32'h202);
    check("align4", 64'(if0.pc_o), 64'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
